cond_flag_unit: RTL and testbench
=================================

COND_FLAG_UNIT -- requirements
Module: cond_flag_unit

Interface
REQ-001 SHALL have parameter MAX_PEND, default 2, meaning the maximum number of flag-setting instructions in flight between issue and ALU writeback.
REQ-002 SHALL have port clk  in  1  system clock; all state changes occur on the rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port alu_valid  in  1  ALU result is retiring this cycle.
REQ-005 SHALL have port alu_s  in  1  the retiring instruction has its S bit set.
REQ-006 SHALL have port alu_arith  in  1  retiring op class: 1 = ADD/ADC/SUB/SBC/RSB/RSC/CMP/CMN; 0 = logical/move.
REQ-007 SHALL have ports alu_n, alu_z, alu_c, alu_v  in  1 each  ALU flag outputs.
REQ-008 SHALL have port shift_c  in  1  shifter carry-out, used as C for logical ops.
REQ-009 SHALL have port flag_wr  in  1  direct NZCV write (MSR-style).
REQ-010 SHALL have port flag_wdata  in  4  NZCV value for flag_wr, bit 3 = N.
REQ-011 SHALL have port issue_valid  in  1  decode presents an instruction.
REQ-012 SHALL have port issue_cond  in  4  ARM condition field.
REQ-013 SHALL have port issue_sets_flags  in  1  the presented instruction will write flags.
REQ-014 SHALL have port issue_ready  out  1  the instruction may issue this cycle.
REQ-015 SHALL have port cond_pass  out  1  condition result; meaningful when issue_valid && issue_ready.
REQ-016 SHALL have port flags  out  4  registered NZCV.
REQ-017 SHALL have port carry_in  out  1  equals flags[1]; feeds the ALU carryIn.
REQ-018 SHALL have port pending  out  1  in-flight flag-setter count is nonzero.
REQ-019 SHALL have port err  out  1  sticky protocol-violation flag.

Function
REQ-020 Flag update SHALL occur when alu_valid && alu_s, taking effect at the next edge.
REQ-021 Arithmetic update (alu_arith=1) SHALL load NZCV = {alu_n, alu_z, alu_c, alu_v}.
REQ-022 Logical update (alu_arith=0) SHALL load N=alu_n, Z=alu_z, C=shift_c, and SHALL hold V.
REQ-023 If flag_wr and an ALU update occur in the same cycle, flag_wr SHALL win.
REQ-024 The pending counter SHALL increment on (issue_valid && issue_ready && issue_sets_flags) and decrement on (alu_valid && alu_s); if both occur, it SHALL be unchanged.
REQ-025 A decrement at count 0 SHALL leave the count at 0, still apply the flag update, and set err.
REQ-026 Condition evaluation SHALL use the forwarded flags: the next-flag value when an ALU update occurs this cycle and count==1, otherwise the registered flags.
REQ-027 issue_ready SHALL be 0 when count>1, or when count==1 with no retiring update; this rule applies unless issue_cond==1110.
REQ-028 issue_ready SHALL also be 0 when issue_sets_flags && count==MAX_PEND and no decrement occurs this cycle.
REQ-029 Conditions SHALL evaluate as follows:
- EQ: Z
- NE: !Z
- CS: C
- CC: !C
- MI: N
- PL: !N
- VS: V
- VC: !V
- HI: C&!Z
- LS: !C|Z
- GE: N==V
- LT: N!=V
- GT: !Z&(N==V)
- LE: Z|(N!=V)
- AL: 1
- 1111: 0
REQ-030 cond_pass SHALL be combinational, with zero cycles of latency from issue_cond.

Reset
REQ-031 Assertion of rst_n=0 SHALL immediately force flags=0000, count=0, err=0, pending=0, and carry_in=0, including while instructions are mid-flight.
REQ-032 After deassertion, writebacks from pre-reset instructions SHALL be treated per REQ-025.

Structure
REQ-033 The condition encodings (EQ..NV) and NZCV bit indices SHALL live in the shared package cond_pkg.
REQ-034 Condition decode SHALL be a combinational sub-module cond_eval (cond[3:0], nzcv[3:0] -> pass).

Verification
REQ-035 A bench SHALL cover these scenarios:
- SUB 0-2 with S (N=1, Z=0, C=0, V=0) -> flags=1000; next MI -> cond_pass=1; CS -> 0.
- CMP 7FFFFFFF,7FFFFFFF (Z=1, C=1) -> flags=0110; EQ pass, HI fail, LS pass.
- ADD 40000000+40000000 (N=1, V=1) -> GE pass, VS pass, GT pass.
- Preset V=1, then logical MOVS result 0 with shift_c=1 -> flags=0111; V held.
- Issue a flag-setter, then present EQ -> issue_ready=0 until the retire cycle, ready=1 that cycle, cond_pass uses the forwarded Z.
- Pending=2, assert rst_n=0 -> flags=0, pending=0 immediately; a later stray retire sets err=1.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared ARM condition-code encodings and NZCV bit positions used by the
// flag unit, its condition decoder and anything that builds NZCV words.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] nzcv_t;

endpackage

// File: rtl/cond_flag_unit_if.sv
// Decode/ALU-side signal bundle of the condition flag unit. Signal names
// match the flag unit's ports so a bench or wrapper can wire them one-to-one.
interface cond_flag_unit_if;
  // ALU writeback side
  logic       alu_valid;
  logic       alu_s;
  logic       alu_arith;
  logic       alu_n;
  logic       alu_z;
  logic       alu_c;
  logic       alu_v;
  logic       shift_c;
  logic       flag_wr;
  logic [3:0] flag_wdata;
  // Decode/issue side
  logic       issue_valid;
  logic [3:0] issue_cond;
  logic       issue_sets_flags;
  logic       issue_ready;
  logic       cond_pass;
  // Status
  logic [3:0] flags;
  logic       carry_in;
  logic       pending;
  logic       err;

  modport master (
    output alu_valid, alu_s, alu_arith, alu_n, alu_z, alu_c, alu_v, shift_c,
           flag_wr, flag_wdata, issue_valid, issue_cond, issue_sets_flags,
    input  issue_ready, cond_pass, flags, carry_in, pending, err
  );

  modport slave (
    input  alu_valid, alu_s, alu_arith, alu_n, alu_z, alu_c, alu_v, shift_c,
           flag_wr, flag_wdata, issue_valid, issue_cond, issue_sets_flags,
    output issue_ready, cond_pass, flags, carry_in, pending, err
  );
endinterface

// File: rtl/cond_eval.sv
// Purely combinational ARM condition decoder: cond field + NZCV -> pass.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    // NOTE: default assigned first so every path drives pass and no latch is inferred.
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// NZCV flag register with in-flight flag-setter tracking, issue interlock,
// single-stage flag forwarding into condition evaluation, and a sticky error.
module cond_flag_unit
  import cond_pkg::*;
#(
  parameter int MAX_PEND = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_valid,
  input  logic       alu_s,
  input  logic       alu_arith,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       shift_c,
  input  logic       flag_wr,
  input  logic [3:0] flag_wdata,
  input  logic       issue_valid,
  input  logic [3:0] issue_cond,
  input  logic       issue_sets_flags,
  output logic       issue_ready,
  output logic       cond_pass,
  output logic [3:0] flags,
  output logic       carry_in,
  output logic       pending,
  output logic       err
);

  localparam int CW = $clog2(MAX_PEND + 1);

  nzcv_t         flags_q, flags_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic  retire, issue_fire;
  logic  count_zero, count_one, count_full;
  logic  hazard, full_block;
  nzcv_t fwd_flags;

  assign retire     = alu_valid & alu_s;
  assign count_zero = (count_q == '0);
  assign count_one  = (count_q == CW'(1));
  assign count_full = (count_q == CW'(MAX_PEND));

  // Direct writes override a same-cycle ALU update; logical ops keep V.
  always_comb begin
    flags_d = flags_q;
    if (flag_wr) begin
      flags_d = flag_wdata;
    end else if (retire) begin
      if (alu_arith) flags_d = {alu_n, alu_z, alu_c, alu_v};
      else           flags_d = {alu_n, alu_z, shift_c, flags_q[FLAG_V]};
    end
  end

  // Only the last outstanding setter can be forwarded; with more in flight
  // the flags a condition depends on are not yet known.
  assign fwd_flags  = (retire && count_one) ? flags_d : flags_q;
  assign hazard     = (issue_cond != COND_AL) &&
                      ((!count_zero && !count_one) || (count_one && !retire));
  assign full_block = issue_sets_flags && count_full && !retire;

  assign issue_ready = !hazard && !full_block;
  assign issue_fire  = issue_valid & issue_ready & issue_sets_flags;

  always_comb begin
    count_d = count_q;
    if (issue_fire && !retire)                    count_d = count_q + CW'(1);
    else if (retire && !issue_fire && !count_zero) count_d = count_q - CW'(1);
  end

  // A retire with nothing outstanding is a protocol violation; it still
  // updates the flags above.
  assign err_d = err_q | (retire & count_zero);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  cond_eval u_cond_eval (
    .cond (issue_cond),
    .nzcv (fwd_flags),
    .pass (cond_pass)
  );

  assign flags    = flags_q;
  assign carry_in = flags_q[FLAG_C];
  assign pending  = !count_zero;
  assign err      = err_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Self-checking bench for cond_flag_unit: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_cond_flag_unit;
  import cond_pkg::*;

  localparam int MAX_PEND = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cond_flag_unit_if bus ();

  cond_flag_unit #(.MAX_PEND(MAX_PEND)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alu_valid        (bus.alu_valid),
    .alu_s            (bus.alu_s),
    .alu_arith        (bus.alu_arith),
    .alu_n            (bus.alu_n),
    .alu_z            (bus.alu_z),
    .alu_c            (bus.alu_c),
    .alu_v            (bus.alu_v),
    .shift_c          (bus.shift_c),
    .flag_wr          (bus.flag_wr),
    .flag_wdata       (bus.flag_wdata),
    .issue_valid      (bus.issue_valid),
    .issue_cond       (bus.issue_cond),
    .issue_sets_flags (bus.issue_sets_flags),
    .issue_ready      (bus.issue_ready),
    .cond_pass        (bus.cond_pass),
    .flags            (bus.flags),
    .carry_in         (bus.carry_in),
    .pending          (bus.pending),
    .err              (bus.err)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  logic [3:0] m_flags;
  int         m_cnt;
  bit         m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 32-bit ALU flags from operands: ARM C is carry-out (no-borrow for SUB).
  function automatic logic [3:0] alu_flags(input logic [31:0] a, input logic [31:0] b, input bit sub);
    logic [32:0] r;
    bit n, z, c, v;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + 33'd1;
    else     r = {1'b0, a} + {1'b0, b};
    n = r[31];
    z = (r[31:0] == 32'd0);
    c = r[32];
    if (sub) v = (a[31] != b[31]) && (r[31] != a[31]);
    else     v = (a[31] == b[31]) && (r[31] != a[31]);
    return {n, z, c, v};
  endfunction

  // Conditions come in complementary pairs: evaluate the even one, invert for odd.
  function automatic bit ref_cond(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return cond[0] ? !base : base;
  endfunction

  task automatic idle();
    bus.alu_valid = 0; bus.alu_s = 0; bus.alu_arith = 0;
    bus.alu_n = 0; bus.alu_z = 0; bus.alu_c = 0; bus.alu_v = 0; bus.shift_c = 0;
    bus.flag_wr = 0; bus.flag_wdata = 4'h0;
    bus.issue_valid = 0; bus.issue_cond = COND_AL; bus.issue_sets_flags = 0;
  endtask

  task automatic drive_issue(input bit iv, input logic [3:0] cond, input bit sets);
    bus.issue_valid = iv; bus.issue_cond = cond; bus.issue_sets_flags = sets;
  endtask

  task automatic drive_alu(input bit av, input bit s, input bit arith, input logic [3:0] nzcv, input bit sc);
    bus.alu_valid = av; bus.alu_s = s; bus.alu_arith = arith;
    {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = nzcv;
    bus.shift_c = sc;
  endtask

  task automatic model_reset();
    m_flags = 4'h0; m_cnt = 0; m_err = 0;
  endtask

  task automatic check_regs(input string tag);
    check($sformatf("%s flags", tag),   bus.flags,    m_flags);
    check($sformatf("%s pending", tag), bus.pending,  (m_cnt != 0));
    check($sformatf("%s carry", tag),   bus.carry_in, m_flags[1]);
    check($sformatf("%s err", tag),     bus.err,      m_err);
  endtask

  // Called just after a negedge with inputs applied; returns at the next negedge.
  task automatic tick(input string tag);
    bit retire, ready, inc, stall;
    logic [3:0] nf, fwd;
    retire = bus.alu_valid && bus.alu_s;
    nf = m_flags;
    if (bus.flag_wr) nf = bus.flag_wdata;
    else if (retire) nf = bus.alu_arith ? {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v}
                                        : {bus.alu_n, bus.alu_z, bus.shift_c, m_flags[0]};
    fwd   = (retire && m_cnt == 1) ? nf : m_flags;
    stall = (bus.issue_cond != 4'hE) && (m_cnt > 1 || (m_cnt == 1 && !retire));
    ready = !stall && !(bus.issue_sets_flags && m_cnt == MAX_PEND && !retire);
    #1;
    check($sformatf("%s ready", tag), bus.issue_ready, ready);
    if (bus.issue_valid && ready)
      check($sformatf("%s pass", tag), bus.cond_pass, ref_cond(bus.issue_cond, fwd));
    inc = bus.issue_valid && ready && bus.issue_sets_flags;
    @(posedge clk);
    m_flags = nf;
    if (retire && m_cnt == 0) m_err = 1;
    if (inc && !retire) m_cnt++;
    else if (retire && !inc && m_cnt > 0) m_cnt--;
    @(negedge clk);
    check_regs(tag);
  endtask

  // One flag-setter issued, then retired on the following cycle.
  task automatic issue_retire(input string tag, input bit arith, input logic [3:0] nzcv, input bit sc);
    idle(); drive_issue(1, COND_AL, 1);
    tick($sformatf("%s issue", tag));
    idle(); drive_alu(1, 1, arith, nzcv, sc);
    tick($sformatf("%s retire", tag));
    idle();
  endtask

  task automatic present(input string tag, input logic [3:0] cond, input bit exp_pass);
    idle(); drive_issue(1, cond, 0);
    tick(tag);
    check($sformatf("%s const", tag), bus.cond_pass, exp_pass);
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_regs("reset");
    rst_n = 1'b1;

    // SUB 0-2
    issue_retire("sub", 1, alu_flags(32'd0, 32'd2, 1), 0);
    check("sub flags const", bus.flags, 4'b1000);
    present("sub MI", COND_MI, 1);
    present("sub CS", COND_CS, 0);

    // CMP equal operands
    issue_retire("cmp", 1, alu_flags(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1), 0);
    check("cmp flags const", bus.flags, 4'b0110);
    present("cmp EQ", COND_EQ, 1);
    present("cmp HI", COND_HI, 0);
    present("cmp LS", COND_LS, 1);

    // ADD with signed overflow
    issue_retire("add", 1, alu_flags(32'h4000_0000, 32'h4000_0000, 0), 0);
    check("add flags const", bus.flags, 4'b1001);
    present("add GE", COND_GE, 1);
    present("add VS", COND_VS, 1);
    present("add GT", COND_GT, 1);

    // Preset V, then logical MOVS result 0 with shifter carry
    idle(); bus.flag_wr = 1; bus.flag_wdata = 4'b0001;
    tick("preset");
    issue_retire("movs", 0, 4'b0100, 1);
    check("movs flags const", bus.flags, 4'b0111);

    // Interlock and forwarding: registered Z=1, retiring Z=0
    idle(); drive_issue(1, COND_AL, 1);
    tick("fwd issue");
    drive_issue(1, COND_EQ, 0);
    tick("fwd stall0");
    check("fwd stall const", bus.issue_ready, 0);
    tick("fwd stall1");
    drive_alu(1, 1, 1, 4'b1010, 0);
    #1;
    check("fwd ready const", bus.issue_ready, 1);
    check("fwd pass const", bus.cond_pass, 0);
    tick("fwd retire");

    // Two in flight, MAX_PEND boundary, then reset mid-flight
    idle(); drive_issue(1, COND_AL, 1);
    tick("pend1");
    tick("pend2");
    #1;
    check("pend full ready", bus.issue_ready, 0);
    idle();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_regs("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    drive_alu(1, 1, 1, 4'b0100, 0);
    tick("stray");
    check("stray err const", bus.err, 1);
    idle();

    // Randomized traffic from a clean state
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      bit iv, sets, av, s;
      iv   = ($urandom_range(0, 3) != 0);
      sets = $urandom_range(0, 1);
      av   = (m_cnt > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      s    = ($urandom_range(0, 7) != 0);
      // Avoid a stray retire coinciding with an issue at count 0.
      if (m_cnt == 0 && iv && sets && av) s = 0;
      drive_issue(iv, 4'($urandom_range(0, 15)), sets);
      drive_alu(av, s, $urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom_range(0, 1));
      bus.flag_wr    = ($urandom_range(0, 15) == 0);
      bus.flag_wdata = 4'($urandom_range(0, 15));
      tick($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
